axis_switch_single_master_rr: RTL and testbench
===============================================

Name: axis_switch_single_master_rr

Overview:
- N-to-1 AXI-Stream arbiter: shares one master stream between NSLAVES requesting slave streams. It is the counterpart of the 1-to-N dest-routed switch.
- Round-robin grant with packet lock: the grant is held until end-of-packet (s_last beat), or until a single beat when HAS_LAST=0.
- Sits in front of shared manager inputs (command/queue streams fed by several accelerators).

Parameters:
NSLAVES, 2, number of slave (requester) streams, >=1
DATA_WIDTH, 64, tdata width per stream
HAS_DEST, 0, 1 = forward tdest
HAS_ID, 0, 1 = forward tid
HAS_LAST, 0, 1 = lock grant until s_last beat; 0 = one beat per grant
ID_WIDTH, 1, tid width
DEST_WIDTH, 1, tdest width
SEL_BITS, $clog2(NSLAVES) (min 1), width of m_sel

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_valid  in  NSLAVES  per-slave tvalid
s_ready  out  NSLAVES  per-slave tready
s_data  in  NSLAVES*DATA_WIDTH  packed tdata, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
s_dest  in  NSLAVES*DEST_WIDTH  packed tdest
s_id  in  NSLAVES*ID_WIDTH  packed tid
s_last  in  NSLAVES  per-slave tlast
m_valid  out  1  master tvalid
m_ready  in  1  master tready
m_data  out  DATA_WIDTH  master tdata
m_dest  out  DEST_WIDTH  master tdest, valid when HAS_DEST
m_id  out  ID_WIDTH  master tid, valid when HAS_ID
m_last  out  1  master tlast, valid when HAS_LAST
m_sel  out  SEL_BITS  index of the currently granted slave

Behaviour:
- NSLAVES==1: pure wire pass-through, no state. s_ready[0]=m_ready; m_valid=s_valid[0]; data/dest/id/last are forwarded; m_sel=0.
- State registers: state {IDLE, TRANSACTION}, sel[SEL_BITS], last_grant[SEL_BITS].
- Reset (async, aresetn=0): state=IDLE, sel=0, last_grant=NSLAVES-1, so the first arbitration favours slave 0.
- Outputs while in reset: m_valid=0, s_ready=all 0, m_sel=0.
- IDLE:
  - m_valid=0, s_ready=0.
  - If any s_valid bit is set, sel <= first index with s_valid=1, searching (last_grant+1) mod NSLAVES upward with wrap. State then goes to TRANSACTION.
  - If no s_valid bit is set, the state holds.
- TRANSACTION:
  - m_valid=s_valid[sel]; s_ready[sel]=m_ready; s_ready[j]=0 for j!=sel.
  - m_data/m_dest/m_id/m_last come from slave sel's slice.
- End of grant:
  - HAS_LAST=0: first handshake (s_valid[sel]&&m_ready).
  - HAS_LAST=1: handshake with s_last[sel]=1.
  - At end of grant: state<=IDLE and last_grant<=sel.
- Mid-packet behaviour: the grant never moves while in TRANSACTION. If s_valid[sel] drops mid-packet, the grant is held and stalls other requesters. Non-granted s_valid changes are ignored.
- Latency/throughput:
  - Each grant costs one IDLE arbitration cycle; the first beat can complete in the cycle after the request is first seen.
  - Back-to-back single-beat grants sustain 1 beat / 2 cycles.
- m_data/m_dest/m_id/m_last in IDLE: the sel slice is driven (don't-care, since m_valid=0). m_sel=sel in all states.
- Fields with HAS_x=0: outputs are driven 0.
- Fairness: after serving slave k, the next grant goes to the nearest requester above k (mod NSLAVES). No requester waits more than NSLAVES-1 grants.
- Reset asserted mid-packet: the FSM returns to IDLE immediately. The packet is truncated (no recovery of a partial packet). After release, arbitration restarts from slave 0.
- Simultaneous requests in IDLE: exactly one is granted, per the round-robin order.

Test Plan:
- Reset, then s_valid=2'b11 (NSLAVES=2, HAS_LAST=0) with m_ready=1 held -> cycle 1 idle; beats then alternate in order slave0, slave1, slave0, each preceded by an idle cycle; m_sel follows 0,1,0.
- HAS_LAST=1: slave1 sends a 3-beat packet (last on beat 3) while slave0 requests from beat 1 -> all 3 slave1 beats pass contiguously with s_ready[0]=0; slave0 is granted after the IDLE cycle that follows.
- Backpressure: m_ready=0 for 4 cycles in TRANSACTION with s_valid[sel]=1 -> m_valid=1, data stable, no state change; the beat completes on the first m_ready=1 cycle.
- NSLAVES=4, only slave 2 requests 3 single beats -> slave 2 is granted each time; m_sel=2; the other s_ready bits stay 0.
- aresetn pulled low asynchronously mid-packet (beat 2 of 4) -> m_valid and s_ready go to 0 without waiting for a clock edge; after release, slaves 0 and 3 both requesting -> slave 0 is granted first.
- NSLAVES=1 -> m_valid/s_ready/m_data follow the inputs combinationally with zero latency.

Source files
------------

// File: rtl/axis_switch_single_master_rr.sv
`default_nettype none
// ============================================================================
// Module      : axis_switch_single_master_rr
// Description : N-to-1 AXI-Stream arbiter. Round-robin grant that is held
//               until the end of a packet (HAS_LAST=1) or a single beat
//               (HAS_LAST=0). NSLAVES==1 degenerates to a wire pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_switch_single_master_rr #(
    parameter int NSLAVES    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int HAS_DEST   = 0,
    parameter int HAS_ID     = 0,
    parameter int HAS_LAST   = 0,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int SEL_BITS   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NSLAVES-1:0]             s_valid,
    output logic [NSLAVES-1:0]             s_ready,
    input  logic [NSLAVES*DATA_WIDTH-1:0]  s_data,
    input  logic [NSLAVES*DEST_WIDTH-1:0]  s_dest,
    input  logic [NSLAVES*ID_WIDTH-1:0]    s_id,
    input  logic [NSLAVES-1:0]             s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [DEST_WIDTH-1:0]          m_dest,
    output logic [ID_WIDTH-1:0]            m_id,
    output logic                           m_last,
    output logic [SEL_BITS-1:0]            m_sel
);

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        TRANSACTION = 1'b1
    } state_t;

    generate
        if (NSLAVES == 1) begin : g_single
            // Single requester: nothing to arbitrate, so no state at all.
            assign s_ready = m_ready;
            assign m_valid = s_valid[0];
            assign m_data  = s_data[DATA_WIDTH-1:0];
            assign m_dest  = (HAS_DEST != 0) ? s_dest[DEST_WIDTH-1:0] : '0;
            assign m_id    = (HAS_ID != 0) ? s_id[ID_WIDTH-1:0] : '0;
            assign m_last  = (HAS_LAST != 0) ? s_last[0] : 1'b0;
            assign m_sel   = '0;
        end else begin : g_multi
            state_t                r_state;
            state_t                w_state_nxt;
            logic [SEL_BITS-1:0]   r_sel;
            logic [SEL_BITS-1:0]   w_sel_nxt;
            logic [SEL_BITS-1:0]   r_last_grant;
            logic [SEL_BITS-1:0]   w_last_grant_nxt;
            logic [SEL_BITS-1:0]   w_pick;
            logic [SEL_BITS-1:0]   w_hi_pick;
            logic [SEL_BITS-1:0]   w_lo_pick;
            logic                  w_hi_found;
            logic                  w_lo_found;
            logic                  w_any;
            logic                  w_hs;
            logic                  w_end;

            logic [DATA_WIDTH-1:0] w_data_arr [NSLAVES];
            logic [DEST_WIDTH-1:0] w_dest_arr [NSLAVES];
            logic [ID_WIDTH-1:0]   w_id_arr   [NSLAVES];

            for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_unpack
                assign w_data_arr[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
                assign w_dest_arr[gi] = s_dest[gi*DEST_WIDTH +: DEST_WIDTH];
                assign w_id_arr[gi]   = s_id[gi*ID_WIDTH +: ID_WIDTH];
            end

            // Round-robin search: the first requester above last_grant wins;
            // if there is none, the lowest requester at or below it (wrap).
            always_comb begin
                w_hi_found = 1'b0;
                w_lo_found = 1'b0;
                w_hi_pick  = '0;
                w_lo_pick  = '0;
                for (int i = 0; i < NSLAVES; i++) begin
                    if (s_valid[i]) begin
                        if (SEL_BITS'(i) > r_last_grant) begin
                            if (!w_hi_found) begin
                                w_hi_found = 1'b1;
                                w_hi_pick  = SEL_BITS'(i);
                            end
                        end else if (!w_lo_found) begin
                            w_lo_found = 1'b1;
                            w_lo_pick  = SEL_BITS'(i);
                        end
                    end
                end
                w_pick = w_hi_found ? w_hi_pick : w_lo_pick;
            end

            assign w_any = |s_valid;
            assign w_hs  = s_valid[r_sel] & m_ready;
            assign w_end = w_hs & ((HAS_LAST != 0) ? s_last[r_sel] : 1'b1);

            // State, grant and round-robin pointer registers.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_state      <= IDLE;
                    r_sel        <= '0;
                    r_last_grant <= SEL_BITS'(NSLAVES - 1);
                end else begin
                    r_state      <= w_state_nxt;
                    r_sel        <= w_sel_nxt;
                    r_last_grant <= w_last_grant_nxt;
                end
            end

            // Next state: arbitrate in IDLE, hold the grant until end of grant.
            always_comb begin
                w_state_nxt      = r_state;
                w_sel_nxt        = r_sel;
                w_last_grant_nxt = r_last_grant;
                case (r_state)
                    IDLE: begin
                        if (w_any) begin
                            w_state_nxt = TRANSACTION;
                            w_sel_nxt   = w_pick;
                        end
                    end
                    TRANSACTION: begin
                        if (w_end) begin
                            w_state_nxt      = IDLE;
                            w_last_grant_nxt = r_sel;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end

            // Handshake routing: only the granted slave sees m_ready.
            always_comb begin
                s_ready = '0;
                m_valid = 1'b0;
                if (r_state == TRANSACTION) begin
                    m_valid        = s_valid[r_sel];
                    s_ready[r_sel] = m_ready;
                end
            end

            assign m_data = w_data_arr[r_sel];
            assign m_dest = (HAS_DEST != 0) ? w_dest_arr[r_sel] : '0;
            assign m_id   = (HAS_ID != 0) ? w_id_arr[r_sel] : '0;
            assign m_last = (HAS_LAST != 0) ? s_last[r_sel] : 1'b0;
            assign m_sel  = r_sel;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_switch_single_master_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_switch_single_master_rr
// Description : Directed self-checking bench for axis_switch_single_master_rr
//               with four configurations (2 single-beat, 2 packet, 4 packet,
//               1 pass-through).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_switch_single_master_rr;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance A: NSLAVES=2, single-beat grants, dest/id forwarded
    logic [1:0]  a_s_valid = '0, a_s_ready, a_s_last = '0;
    logic [15:0] a_s_data = '0;
    logic [3:0]  a_s_dest = '0, a_s_id = '0;
    logic        a_m_valid, a_m_ready = 1'b0, a_m_last;
    logic [7:0]  a_m_data;
    logic [1:0]  a_m_dest, a_m_id;
    logic [0:0]  a_m_sel;

    axis_switch_single_master_rr #(.NSLAVES(2), .DATA_WIDTH(8), .HAS_DEST(1), .HAS_ID(1),
        .HAS_LAST(0), .ID_WIDTH(2), .DEST_WIDTH(2)) u_rr2 (
        .aclk(clk), .aresetn(aresetn), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .s_dest(a_s_dest), .s_id(a_s_id), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_dest(a_m_dest),
        .m_id(a_m_id), .m_last(a_m_last), .m_sel(a_m_sel));

    // Instance B: NSLAVES=2, packet lock, dest not forwarded
    logic [1:0]  b_s_valid = '0, b_s_ready, b_s_last = '0, b_s_id = '0;
    logic [15:0] b_s_data = '0;
    logic [3:0]  b_s_dest = '0;
    logic        b_m_valid, b_m_ready = 1'b0, b_m_last;
    logic [7:0]  b_m_data;
    logic [1:0]  b_m_dest;
    logic [0:0]  b_m_id;
    logic [0:0]  b_m_sel;

    axis_switch_single_master_rr #(.NSLAVES(2), .DATA_WIDTH(8), .HAS_DEST(0), .HAS_ID(0),
        .HAS_LAST(1), .ID_WIDTH(1), .DEST_WIDTH(2)) u_pk2 (
        .aclk(clk), .aresetn(aresetn), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_dest(b_s_dest), .s_id(b_s_id), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_dest(b_m_dest),
        .m_id(b_m_id), .m_last(b_m_last), .m_sel(b_m_sel));

    // Instance C: NSLAVES=4, packet lock
    logic [3:0]  c_s_valid = '0, c_s_ready, c_s_last = '0, c_s_dest = '0, c_s_id = '0;
    logic [31:0] c_s_data = '0;
    logic        c_m_valid, c_m_ready = 1'b0, c_m_last;
    logic [7:0]  c_m_data;
    logic [0:0]  c_m_dest, c_m_id;
    logic [1:0]  c_m_sel;

    axis_switch_single_master_rr #(.NSLAVES(4), .DATA_WIDTH(8), .HAS_LAST(1)) u_rr4 (
        .aclk(clk), .aresetn(aresetn), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_data(c_s_data), .s_dest(c_s_dest), .s_id(c_s_id), .s_last(c_s_last),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_dest(c_m_dest),
        .m_id(c_m_id), .m_last(c_m_last), .m_sel(c_m_sel));

    // Instance D: NSLAVES=1 pass-through
    logic [0:0]  d_s_valid = '0, d_s_ready, d_s_last = '0, d_s_dest = '0, d_s_id = '0;
    logic [7:0]  d_s_data = '0;
    logic        d_m_valid, d_m_ready = 1'b0, d_m_last;
    logic [7:0]  d_m_data;
    logic [0:0]  d_m_dest, d_m_id;
    logic [0:0]  d_m_sel;

    axis_switch_single_master_rr #(.NSLAVES(1), .DATA_WIDTH(8), .HAS_LAST(1)) u_one (
        .aclk(clk), .aresetn(aresetn), .s_valid(d_s_valid), .s_ready(d_s_ready),
        .s_data(d_s_data), .s_dest(d_s_dest), .s_id(d_s_id), .s_last(d_s_last),
        .m_valid(d_m_valid), .m_ready(d_m_ready), .m_data(d_m_data), .m_dest(d_m_dest),
        .m_id(d_m_id), .m_last(d_m_last), .m_sel(d_m_sel));

    task automatic test_reset();
        @(negedge clk);
        a_s_valid = 2'b11;
        #1;
        n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", a_m_valid); end
        n_checks++; if (a_s_ready !== 2'b00) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 00", a_s_ready); end
        n_checks++; if (a_m_sel !== 1'b0) begin n_fail++; $display("FAIL reset_m_sel: got %b expected 0", a_m_sel); end
        n_checks++; if (c_m_sel !== 2'd0) begin n_fail++; $display("FAIL reset_m_sel4: got %0d expected 0", c_m_sel); end
        @(negedge clk);
        a_s_valid = 2'b00;
        aresetn = 1'b1;
    endtask

    task automatic test_rr_alternate();
        logic       exp_valid [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_ready [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic       exp_sel   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_data  [6] = '{8'hA0, 8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hA0};
        logic [1:0] exp_id    [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        @(negedge clk);
        a_s_data  = {8'hB1, 8'hA0};
        a_s_id    = {2'b10, 2'b01};
        a_s_dest  = {2'b01, 2'b10};
        a_m_ready = 1'b1;
        a_s_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++; if (a_m_valid !== exp_valid[i]) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected %b", i, a_m_valid, exp_valid[i]); end
            n_checks++; if (a_s_ready !== exp_ready[i]) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, a_s_ready, exp_ready[i]); end
            n_checks++; if (a_m_sel !== exp_sel[i]) begin n_fail++; $display("FAIL rr_sel[%0d]: got %b expected %b", i, a_m_sel, exp_sel[i]); end
            if (exp_valid[i]) begin
                n_checks++; if (a_m_data !== exp_data[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", i, a_m_data, exp_data[i]); end
                n_checks++; if (a_m_id !== exp_id[i]) begin n_fail++; $display("FAIL rr_id[%0d]: got %b expected %b", i, a_m_id, exp_id[i]); end
            end
            @(negedge clk);
        end
        a_s_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_s_valid = 2'b01;
        a_s_data  = {8'h00, 8'h5C};
        a_m_ready = 1'b0;
        #1;
        n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid: got %b expected 0", a_m_valid); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (a_m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, a_m_valid); end
            n_checks++; if (a_m_data !== 8'h5C) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected 5c", k, a_m_data); end
            n_checks++; if (a_s_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, a_s_ready); end
            @(negedge clk);
        end
        a_m_ready = 1'b1;
        #1;
        n_checks++; if (a_s_ready !== 2'b01) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 01", a_s_ready); end
        n_checks++; if (a_m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 1", a_m_valid); end
        @(negedge clk);
        a_s_valid = 2'b00;
        #1;
        n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %b expected 0", a_m_valid); end
    endtask

    task automatic test_packet_lock();
        @(negedge clk);
        b_s_valid = 2'b10;
        b_s_data  = {8'h11, 8'h0A};
        b_s_last  = 2'b00;
        b_s_dest  = 4'hF;
        b_m_ready = 1'b1;
        @(negedge clk);
        b_s_valid = 2'b11;
        for (int b = 0; b < 3; b++) begin
            b_s_data[15:8] = 8'(17 + b);
            b_s_last[1]    = (b == 2);
            #1;
            n_checks++; if (b_m_valid !== 1'b1) begin n_fail++; $display("FAIL pk_valid[%0d]: got %b expected 1", b, b_m_valid); end
            n_checks++; if (b_s_ready !== 2'b10) begin n_fail++; $display("FAIL pk_ready[%0d]: got %b expected 10", b, b_s_ready); end
            n_checks++; if (b_m_sel !== 1'b1) begin n_fail++; $display("FAIL pk_sel[%0d]: got %b expected 1", b, b_m_sel); end
            n_checks++; if (b_m_data !== 8'(17 + b)) begin n_fail++; $display("FAIL pk_data[%0d]: got %h expected %h", b, b_m_data, 8'(17 + b)); end
            n_checks++; if (b_m_last !== (b == 2)) begin n_fail++; $display("FAIL pk_last[%0d]: got %b expected %b", b, b_m_last, (b == 2)); end
            n_checks++; if (b_m_dest !== 2'b00) begin n_fail++; $display("FAIL pk_dest_zero[%0d]: got %b expected 00", b, b_m_dest); end
            @(negedge clk);
        end
        b_s_valid = 2'b01;
        b_s_last  = 2'b01;
        #1;
        n_checks++; if (b_m_valid !== 1'b0) begin n_fail++; $display("FAIL pk_gap_valid: got %b expected 0", b_m_valid); end
        n_checks++; if (b_s_ready !== 2'b00) begin n_fail++; $display("FAIL pk_gap_ready: got %b expected 00", b_s_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (b_m_sel !== 1'b0) begin n_fail++; $display("FAIL pk_next_sel: got %b expected 0", b_m_sel); end
        n_checks++; if (b_s_ready !== 2'b01) begin n_fail++; $display("FAIL pk_next_ready: got %b expected 01", b_s_ready); end
        n_checks++; if (b_m_data !== 8'h0A) begin n_fail++; $display("FAIL pk_next_data: got %h expected 0a", b_m_data); end
        @(negedge clk);
        b_s_valid = 2'b00;
    endtask

    task automatic test_single_requester();
        @(negedge clk);
        c_s_valid = 4'b0100;
        c_s_last  = 4'b0100;
        c_s_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        c_m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i % 2 == 1) begin
                n_checks++; if (c_m_valid !== 1'b1) begin n_fail++; $display("FAIL sr_valid[%0d]: got %b expected 1", i, c_m_valid); end
                n_checks++; if (c_m_sel !== 2'd2) begin n_fail++; $display("FAIL sr_sel[%0d]: got %0d expected 2", i, c_m_sel); end
                n_checks++; if (c_s_ready !== 4'b0100) begin n_fail++; $display("FAIL sr_ready[%0d]: got %b expected 0100", i, c_s_ready); end
                n_checks++; if (c_m_data !== 8'h22) begin n_fail++; $display("FAIL sr_data[%0d]: got %h expected 22", i, c_m_data); end
            end else begin
                n_checks++; if (c_m_valid !== 1'b0) begin n_fail++; $display("FAIL sr_idle_valid[%0d]: got %b expected 0", i, c_m_valid); end
                n_checks++; if (c_s_ready !== 4'b0000) begin n_fail++; $display("FAIL sr_idle_ready[%0d]: got %b expected 0000", i, c_s_ready); end
            end
            @(negedge clk);
        end
        c_s_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        c_s_valid = 4'b1000;
        c_s_last  = 4'b0000;
        @(negedge clk);
        #1;
        n_checks++; if (c_m_sel !== 2'd3) begin n_fail++; $display("FAIL ar_beat1_sel: got %0d expected 3", c_m_sel); end
        @(negedge clk);
        #1;
        n_checks++; if (c_m_valid !== 1'b1) begin n_fail++; $display("FAIL ar_beat2_valid: got %b expected 1", c_m_valid); end
        n_checks++; if (c_s_ready !== 4'b1000) begin n_fail++; $display("FAIL ar_beat2_ready: got %b expected 1000", c_s_ready); end
        #1;
        aresetn = 1'b0;
        #1;
        n_checks++; if (c_m_valid !== 1'b0) begin n_fail++; $display("FAIL ar_async_valid: got %b expected 0", c_m_valid); end
        n_checks++; if (c_s_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_async_ready: got %b expected 0000", c_s_ready); end
        n_checks++; if (c_m_sel !== 2'd0) begin n_fail++; $display("FAIL ar_async_sel: got %0d expected 0", c_m_sel); end
        @(negedge clk);
        aresetn   = 1'b1;
        c_s_valid = 4'b1001;
        c_s_last  = 4'b1001;
        c_s_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        #1;
        n_checks++; if (c_m_valid !== 1'b0) begin n_fail++; $display("FAIL ar_release_valid: got %b expected 0", c_m_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (c_m_sel !== 2'd0) begin n_fail++; $display("FAIL ar_first_sel: got %0d expected 0", c_m_sel); end
        n_checks++; if (c_s_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_ready: got %b expected 0001", c_s_ready); end
        n_checks++; if (c_m_data !== 8'hD0) begin n_fail++; $display("FAIL ar_first_data: got %h expected d0", c_m_data); end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (c_m_sel !== 2'd3) begin n_fail++; $display("FAIL ar_second_sel: got %0d expected 3", c_m_sel); end
        n_checks++; if (c_m_data !== 8'hD3) begin n_fail++; $display("FAIL ar_second_data: got %h expected d3", c_m_data); end
        n_checks++; if (c_s_ready !== 4'b1000) begin n_fail++; $display("FAIL ar_second_ready: got %b expected 1000", c_s_ready); end
        @(negedge clk);
        c_s_valid = 4'b0000;
    endtask

    task automatic test_passthrough();
        logic       v_valid [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       v_ready [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] v_data  [4] = '{8'h3C, 8'hC3, 8'h5A, 8'hFF};
        logic       v_last  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d_s_valid[0] = v_valid[i];
            d_m_ready    = v_ready[i];
            d_s_data     = v_data[i];
            d_s_last[0]  = v_last[i];
            #1;
            n_checks++; if (d_m_valid !== v_valid[i]) begin n_fail++; $display("FAIL pt_valid[%0d]: got %b expected %b", i, d_m_valid, v_valid[i]); end
            n_checks++; if (d_s_ready[0] !== v_ready[i]) begin n_fail++; $display("FAIL pt_ready[%0d]: got %b expected %b", i, d_s_ready, v_ready[i]); end
            n_checks++; if (d_m_data !== v_data[i]) begin n_fail++; $display("FAIL pt_data[%0d]: got %h expected %h", i, d_m_data, v_data[i]); end
            n_checks++; if (d_m_last !== v_last[i]) begin n_fail++; $display("FAIL pt_last[%0d]: got %b expected %b", i, d_m_last, v_last[i]); end
            n_checks++; if (d_m_sel !== 1'b0) begin n_fail++; $display("FAIL pt_sel[%0d]: got %b expected 0", i, d_m_sel); end
        end
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_backpressure();
        test_packet_lock();
        test_single_requester();
        test_async_reset();
        test_passthrough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
